// File: rtl/vote_controller.sv
// rtl/vote_controller.sv - voting machine central controller
//
// Purpose: accepts one-hot vote pulses, rejects multi-hot requests, keeps
// saturating per-candidate tallies and a saturating total, enforces a fixed
// inter-vote lockout, and in result mode exposes a selected tally.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset (release synchronised here)
//   valid_vote   in   per-candidate single-cycle vote pulses
//   mode         in   0 = voting, 1 = result display
//   clear_counts in   zero all tallies and total, honoured only in RESULT
//   result_sel   in   candidate index driving result_count
//   vote_ack     out  1-cycle pulse, vote committed
//   vote_err     out  1-cycle pulse, multi-hot request rejected
//   busy         out  high while in LOCKOUT
//   result_count out  registered tally[result_sel] when mode=1, else 0
//   total_votes  out  saturating total of accepted votes
module vote_controller #(
  parameter int N_CAND         = 4,
  parameter int CNT_W          = 8,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_CAND-1:0]         valid_vote,
  input  logic                      mode,
  input  logic                      clear_counts,
  input  logic [$clog2(N_CAND)-1:0] result_sel,
  output logic                      vote_ack,
  output logic                      vote_err,
  output logic                      busy,
  output logic [CNT_W-1:0]          result_count,
  output logic [CNT_W-1:0]          total_votes
);

  localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [N_CAND-1:0] VV_ONE = N_CAND'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKOUT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  // Reset synchroniser: assertion is immediate, release waits two edges.
  logic rst_meta_q, rst_n_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  state_t           state_q, state_d;
  logic [LCK_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] tally_q [N_CAND];
  logic [CNT_W-1:0] tally_d [N_CAND];
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] res_q, res_d;

  logic any_req, multi_req;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any_req   = |valid_vote;
  assign multi_req = |(valid_vote & (valid_vote - VV_ONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tally_d = tally_q;
    total_d = total_q;

    case (state_q)
      IDLE: begin
        if (mode) begin
          state_d = RESULT;
        end else if (multi_req) begin
          err_d = 1'b1;
        end else if (any_req) begin
          ack_d   = 1'b1;
          state_d = LOCKOUT;
          cnt_d   = LCK_W'(LOCKOUT_CYCLES);
          for (int i = 0; i < N_CAND; i++) begin
            if (valid_vote[i] && (tally_q[i] != '1)) begin
              tally_d[i] = tally_q[i] + CNT_W'(1);
            end
          end
          if (total_q != '1) begin
            total_d = total_q + CNT_W'(1);
          end
        end
      end

      LOCKOUT: begin
        cnt_d = cnt_q - LCK_W'(1);
        // cnt_q counts LOCKOUT_CYCLES..1, so leaving at 1 gives the exact length.
        if (cnt_q == LCK_W'(1)) begin
          state_d = mode ? RESULT : IDLE;
        end
      end

      RESULT: begin
        if (clear_counts) begin
          for (int i = 0; i < N_CAND; i++) begin
            tally_d[i] = '0;
          end
          total_d = '0;
        end
        if (!mode) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_d = '0;
    if (mode && (int'(result_sel) < N_CAND)) begin
      res_d = tally_q[result_sel];
    end
  end

  always_ff @(posedge clock or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      total_q <= '0;
      res_q   <= '0;
      for (int i = 0; i < N_CAND; i++) begin
        tally_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      total_q <= total_d;
      res_q   <= res_d;
      for (int i = 0; i < N_CAND; i++) begin
        tally_q[i] <= tally_d[i];
      end
    end
  end

  assign vote_ack     = ack_q;
  assign vote_err     = err_q;
  assign busy         = (state_q == LOCKOUT);
  assign result_count = res_q;
  assign total_votes  = total_q;

endmodule

// File: tb/tb_vote_controller.sv
// tb/tb_vote_controller.sv - self-checking bench for vote_controller
module tb_vote_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] valid_vote = '0;
  logic       mode = 1'b0;
  logic       clear_counts = 1'b0;
  logic [1:0] result_sel = '0;
  logic       vote_ack, vote_err, busy;
  logic [3:0] result_count, total_votes;

  int n_checks = 0;
  int n_fail   = 0;

  vote_controller #(.N_CAND(4), .CNT_W(4), .LOCKOUT_CYCLES(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_vote   (valid_vote),
    .mode         (mode),
    .clear_counts (clear_counts),
    .result_sel   (result_sel),
    .vote_ack     (vote_ack),
    .vote_err     (vote_err),
    .busy         (busy),
    .result_count (result_count),
    .total_votes  (total_votes)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] vv;
    logic       ack;
    logic       err;
    logic       bsy;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    valid_vote = '0;
    mode = 1'b0;
    clear_counts = 1'b0;
    result_sel = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic pulse(input logic [3:0] v);
    valid_vote = v;
    tick();
    valid_vote = '0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
    end
    if (busy) chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic read_tally(input int k, input int exp, input string name);
    mode = 1'b1;
    result_sel = 2'(k);
    tick();
    tick();
    chk(name, int'(result_count), exp);
  endtask

  task automatic leave_result();
    mode = 1'b0;
    tick();
  endtask

  initial begin
    vec_t vecs[9];
    int   bcnt;
    int   guard;

    vecs[0] = '{4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b0100, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{4'b1010, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'b0001, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{4'b1111, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'b1000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{4'b0010, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{4'b0110, 1'b0, 1'b1, 1'b0};

    #2;
    do_reset();
    chk("reset_ack",    int'(vote_ack), 0);
    chk("reset_err",    int'(vote_err), 0);
    chk("reset_busy",   int'(busy), 0);
    chk("reset_total",  int'(total_votes), 0);
    chk("reset_result", int'(result_count), 0);

    // Table: each request from IDLE, with lockout drained between entries.
    for (int i = 0; i < 9; i++) begin
      pulse(vecs[i].vv);
      chk($sformatf("vec%0d_ack", i),  int'(vote_ack), int'(vecs[i].ack));
      chk($sformatf("vec%0d_err", i),  int'(vote_err), int'(vecs[i].err));
      chk($sformatf("vec%0d_busy", i), int'(busy),     int'(vecs[i].bsy));
      wait_idle($sformatf("vec%0d", i));
    end
    chk("vec_total", int'(total_votes), 4);
    for (int k = 0; k < 4; k++) read_tally(k, 1, $sformatf("vec_tally%0d", k));
    leave_result();
    chk("result_zero_in_voting", int'(result_count), 0);

    // Single vote: ack one cycle, busy exactly 16 cycles.
    do_reset();
    pulse(4'b0100);
    chk("t1_ack", int'(vote_ack), 1);
    bcnt = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
      if (busy) bcnt++;
      if (guard == 1) chk("t1_ack_one_cycle", int'(vote_ack), 0);
    end
    chk("t1_busy_cycles", bcnt, 16);
    chk("t1_total", int'(total_votes), 1);
    read_tally(2, 1, "t1_tally2");
    read_tally(0, 0, "t1_tally0");
    leave_result();

    // Simultaneous request rejected.
    do_reset();
    pulse(4'b0011);
    chk("t2_err", int'(vote_err), 1);
    chk("t2_ack", int'(vote_ack), 0);
    chk("t2_busy", int'(busy), 0);
    tick();
    chk("t2_err_one_cycle", int'(vote_err), 0);
    chk("t2_total", int'(total_votes), 0);
    for (int k = 0; k < 4; k++) read_tally(k, 0, $sformatf("t2_tally%0d", k));
    leave_result();

    // Votes during lockout are ignored.
    do_reset();
    pulse(4'b0010);
    chk("t3_ack1", int'(vote_ack), 1);
    tick();
    tick();
    tick();
    tick();
    pulse(4'b1000);
    chk("t3_lock_ack", int'(vote_ack), 0);
    chk("t3_lock_err", int'(vote_err), 0);
    chk("t3_lock_busy", int'(busy), 1);
    pulse(4'b1100);
    chk("t3_lock_multi_err", int'(vote_err), 0);
    wait_idle("t3a");
    read_tally(1, 1, "t3_tally1");
    read_tally(3, 0, "t3_tally3_blocked");
    leave_result();
    pulse(4'b1000);
    chk("t3_ack2", int'(vote_ack), 1);
    wait_idle("t3b");
    read_tally(3, 1, "t3_tally3");
    leave_result();
    chk("t3_total", int'(total_votes), 2);

    // Saturation at 15 with every vote acked.
    do_reset();
    for (int v = 0; v < 16; v++) begin
      pulse(4'b0001);
      chk($sformatf("t4_ack%0d", v), int'(vote_ack), 1);
      wait_idle("t4");
    end
    chk("t4_total", int'(total_votes), 15);
    read_tally(0, 15, "t4_tally0");
    leave_result();

    // Result display and clear.
    do_reset();
    for (int v = 0; v < 3; v++) begin
      pulse(4'b0100);
      wait_idle("t5");
    end
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    chk("t5_clear_ignored_idle", int'(total_votes), 3);
    mode = 1'b1;
    result_sel = 2'd2;
    tick();
    chk("t5_result", int'(result_count), 3);
    pulse(4'b0001);
    chk("t5_result_vote_ack", int'(vote_ack), 0);
    chk("t5_result_busy", int'(busy), 0);
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    chk("t5_total_cleared", int'(total_votes), 0);
    tick();
    chk("t5_result_cleared", int'(result_count), 0);
    leave_result();
    pulse(4'b0010);
    chk("t5_ack_after", int'(vote_ack), 1);
    chk("t5_total_after", int'(total_votes), 1);
    wait_idle("t5b");

    // Asynchronous reset in the middle of lockout.
    do_reset();
    pulse(4'b0001);
    tick();
    tick();
    chk("t6_busy_before", int'(busy), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_busy_async", int'(busy), 0);
    chk("t6_total_async", int'(total_votes), 0);
    chk("t6_result_async", int'(result_count), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    pulse(4'b1000);
    chk("t6_ack_after", int'(vote_ack), 1);
    chk("t6_total_after", int'(total_votes), 1);
    wait_idle("t6");
    read_tally(0, 0, "t6_tally0");
    read_tally(3, 1, "t6_tally3");
    leave_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
